score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Score keeper for a two-player paddle game.
// Awards points when the ball leaves play, holds between points, then either
// serves a new ball or declares the match winner.
// Optional feature: define SCORE_RALLY_EN to build the rally hit counter;
// without it, rally is tied to zero and no counter logic exists.
module score_keeper #(
  parameter int WIN_SCORE  = 7,
  parameter int HOLD_TICKS = 120,
  parameter int MID_Y      = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_end,
  input  logic [9:0] ball_y,
  input  logic [1:0] paddle_hit,
  input  logic       start,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [7:0] rally,
  output logic       serve,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int              CNT_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [3:0]      WIN       = 4'(WIN_SCORE);
  localparam logic [9:0]      MID       = 10'(MID_Y);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  hold_cnt;
  logic              game_end_q;
  logic              ge_rise;
  logic              award;
  logic              leave_hold;
  logic              new_match;
  logic              win_reached;

  assign ge_rise     = game_end & ~game_end_q;
  assign win_reached = (score1 == WIN) || (score2 == WIN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PLAY;
    else       state <= next_state;
  end

  // Next-state decode and the one-cycle action strobes the datapath acts on
  always_comb begin
    next_state = state;
    award      = 1'b0;
    leave_hold = 1'b0;
    new_match  = 1'b0;
    unique case (state)
      PLAY: begin
        if (ge_rise) begin
          award      = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          leave_hold = 1'b1;
          next_state = win_reached ? OVER : PLAY;
        end
      end
      OVER: begin
        if (start) begin
          new_match  = 1'b1;
          next_state = PLAY;
        end
      end
      default: next_state = PLAY;
    endcase
  end

  // Scores, hold timer, serve pulse and match result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      game_end_q <= 1'b0;
      hold_cnt   <= '0;
      score1     <= '0;
      score2     <= '0;
      serve      <= 1'b0;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      game_end_q <= game_end;
      serve      <= 1'b0;
      if (award) begin
        hold_cnt <= HOLD_LOAD;
        if (ball_y < MID) begin
          if (score2 != WIN) score2 <= score2 + 4'd1;
        end else begin
          if (score1 != WIN) score1 <= score1 + 4'd1;
        end
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (leave_hold) begin
        if (win_reached) begin
          match_over <= 1'b1;
          winner     <= (score1 == WIN) ? 2'b01 : 2'b10;
        end else begin
          serve <= 1'b1;
        end
      end
      if (new_match) begin
        score1     <= '0;
        score2     <= '0;
        winner     <= 2'b00;
        match_over <= 1'b0;
        serve      <= 1'b1;
      end
    end
  end

`ifdef SCORE_RALLY_EN
  logic [1:0] paddle_q;
  logic       paddle_rise;
  logic       clear_rally;

  assign paddle_rise = |(paddle_hit & ~paddle_q);
  assign clear_rally = (leave_hold && !win_reached) || new_match;

  // Rally hit counter; a simultaneous point wins over a paddle hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddle_q <= 2'b00;
      rally    <= 8'd0;
    end else begin
      paddle_q <= paddle_hit;
      if (clear_rally) begin
        rally <= 8'd0;
      end else if (state == PLAY && paddle_rise && !ge_rise && rally != 8'hFF) begin
        rally <= rally + 8'd1;
      end
    end
  end
`else
  logic unused_paddle;
  assign unused_paddle = ^paddle_hit;
  assign rally         = 8'd0;
`endif

endmodule
